iob_iob2wishbone: RTL and testbench

IOB_IOB2WISHBONE -- requirements
Module: iob_iob2wishbone

---
 rtl/iob_wishbone_pkg.sv | 18 +
 rtl/iob_iob2wishbone_if.sv | 43 ++++
 rtl/iob_reg.sv | 29 ++
 rtl/iob_iob2wishbone.sv | 140 ++++++++++++++
 tb/tb_iob_iob2wishbone.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_wishbone_pkg.sv
// Shared definitions for the IOb <-> Wishbone bridges.
// Holds the bridge FSM state encoding and the width of the bus-cycle
// watchdog counter so both bridge directions agree on them.
package iob_wishbone_pkg;

  // Width of the cycle counter that bounds how long a bridge waits for
  // the far side to respond.
  localparam int CNT_W = 16;

  // Bridge FSM states; encodings are fixed so waveforms and any external
  // observers read the same values for both bridges.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iob_iob2wishbone_if.sv
// Signal bundle for the IOb-to-Wishbone bridge.
// Groups the IOb request/response and the Wishbone master request/response.
//   modport slave  : the bridge's view (takes IOb requests, masters Wishbone)
//   modport master : the environment's view (issues IOb requests, acts as
//                    the Wishbone slave)
interface iob_iob2wishbone_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // IOb side
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic                error;

  // Wishbone side
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_wdata;
  logic [DATA_W/8-1:0] wb_select;
  logic                wb_we;
  logic                wb_cyc;
  logic                wb_stb;
  logic [DATA_W-1:0]   wb_rdata;
  logic                wb_ack;
  logic                wb_error;

  modport slave (
    input  valid, address, wdata, wstrb, wb_rdata, wb_ack, wb_error,
    output rdata, ready, error, wb_addr, wb_wdata, wb_select, wb_we,
           wb_cyc, wb_stb
  );

  modport master (
    output valid, address, wdata, wstrb, wb_rdata, wb_ack, wb_error,
    input  rdata, ready, error, wb_addr, wb_wdata, wb_select, wb_we,
           wb_cyc, wb_stb
  );

endinterface

// File: rtl/iob_reg.sv
// Generic clock-enabled register with asynchronous active-low reset.
// Ports:
//   clk_i    : rising-edge clock
//   arst_n_i : asynchronous active-low reset, loads RST_VAL
//   cke_i    : load enable
//   data_i   : next value
//   data_o   : registered value
module iob_reg #(
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_iob2wishbone.sv
// IOb slave to Wishbone master bridge.
// Captures one IOb request, runs it as a single Wishbone classic cycle from
// registered values, and returns a one-cycle ready_o (with error_o on slave
// error or watchdog expiry).
// Ports:
//   clk_i, arst_n_i                      : clock, async active-low reset
//   valid_i, address_i, wdata_i, wstrb_i : IOb request (wstrb_i==0 is a read)
//   rdata_o, ready_o, error_o            : IOb response, valid while ready_o
//   wb_addr_o .. wb_stb_o                : Wishbone master request
//   wb_data_i, wb_ack_i, wb_error_i      : Wishbone slave response
module iob_iob2wishbone
  import iob_wishbone_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,

  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                error_o,

  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic [DATA_W/8-1:0] wb_select_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_error_i
);

  localparam int STRB_W = DATA_W / 8;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic               req_load;
  logic               write_q;
  logic               timeout;
  logic               bus_end;
  logic               rsp_err;
  logic [DATA_W-1:0]  rsp_data;

  assign req_load = (state == IDLE) && valid_i;
  assign write_q  = |wstrb_q;
  assign timeout  = (cnt == CNT_W'(TIMEOUT));
  assign bus_end  = (state == BUS) && (wb_ack_i || wb_error_i || timeout);

  // Error wins over ack; the watchdog only fires when the slave is silent.
  assign rsp_err  = wb_error_i || (!wb_ack_i && timeout);
  assign rsp_data = (wb_ack_i && !wb_error_i && !write_q) ? wb_data_i : '0;

  // Request captured in IDLE so Wishbone is never driven from IOb inputs.
  iob_reg #(.DATA_W(ADDR_W + DATA_W + STRB_W)) req_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (req_load),
    .data_i   ({address_i, wdata_i, wstrb_i}),
    .data_o   ({addr_q, wdata_q, wstrb_q})
  );

  // Response captured on the cycle that closes the Wishbone transfer.
  iob_reg #(.DATA_W(DATA_W + 1)) rsp_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (bus_end),
    .data_i   ({rsp_data, rsp_err}),
    .data_o   ({rdata_q, err_q})
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Cleared whenever not in BUS, so it reads 0 on the first BUS cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt <= '0;
    end else if (state == BUS) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign wb_addr_o = addr_q;
  assign wb_data_o = wdata_q;

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_select_o = '0;
    ready_o     = 1'b0;
    error_o     = 1'b0;
    rdata_o     = '0;

    case (state)
      IDLE: begin
        if (valid_i) state_nxt = BUS;
      end
      BUS: begin
        wb_cyc_o    = 1'b1;
        wb_stb_o    = 1'b1;
        wb_we_o     = write_q;
        wb_select_o = write_q ? wstrb_q : '1;
        if (bus_end) state_nxt = DONE;
      end
      DONE: begin
        ready_o   = 1'b1;
        error_o   = err_q;
        rdata_o   = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// Directed self-checking bench for iob_iob2wishbone (TIMEOUT = 4).
// Cycle 0 is the cycle in which valid_i is first presented; outputs are
// sampled 1 time unit after each rising edge.
module tb_iob_iob2wishbone;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk;
  logic arst_n;
  int   n_cmp;
  int   n_bad;

  iob_iob2wishbone_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_iob2wishbone #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .valid_i     (bus.valid),
    .address_i   (bus.address),
    .wdata_i     (bus.wdata),
    .wstrb_i     (bus.wstrb),
    .rdata_o     (bus.rdata),
    .ready_o     (bus.ready),
    .error_o     (bus.error),
    .wb_addr_o   (bus.wb_addr),
    .wb_data_o   (bus.wb_wdata),
    .wb_select_o (bus.wb_select),
    .wb_we_o     (bus.wb_we),
    .wb_cyc_o    (bus.wb_cyc),
    .wb_stb_o    (bus.wb_stb),
    .wb_data_i   (bus.wb_rdata),
    .wb_ack_i    (bus.wb_ack),
    .wb_error_i  (bus.wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.wb_rdata = '0; bus.wb_ack = 1'b0; bus.wb_error = 1'b0;
    tick; tick;
    n_cmp++;
    if ({bus.rdata, bus.ready, bus.error, bus.wb_addr, bus.wb_wdata, bus.wb_select,
         bus.wb_we, bus.wb_cyc, bus.wb_stb} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdata=%h ready=%b error=%b addr=%h data=%h sel=%h we=%b cyc=%b stb=%b, expected all zero",
               bus.rdata, bus.ready, bus.error, bus.wb_addr, bus.wb_wdata, bus.wb_select,
               bus.wb_we, bus.wb_cyc, bus.wb_stb);
    end
    arst_n = 1'b1;
    tick; tick;
    n_cmp++;
    if ({bus.wb_cyc, bus.wb_stb, bus.ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle_no_valid: got cyc/stb/ready=%b expected 000",
               {bus.wb_cyc, bus.wb_stb, bus.ready});
    end
  endtask

  task automatic test_stray_response;
    bus.wb_ack = 1'b1; bus.wb_error = 1'b1; bus.wb_rdata = 32'hFFFF_FFFF;
    tick;
    bus.wb_ack = 1'b0; bus.wb_error = 1'b0; bus.wb_rdata = '0;
    tick;
    n_cmp++;
    if ({bus.ready, bus.error, bus.wb_stb, bus.rdata} !== {3'b000, 32'h0}) begin
      n_bad++;
      $display("FAIL stray_ack: got ready=%b error=%b stb=%b rdata=%h expected 0 0 0 0",
               bus.ready, bus.error, bus.wb_stb, bus.rdata);
    end
  endtask

  task automatic test_read;
    bus.valid = 1'b1; bus.address = 32'h10; bus.wdata = '0; bus.wstrb = 4'h0;
    tick;                                                     // cycle 1
    n_cmp++;
    if ({bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_select, bus.wb_addr} !==
        {3'b110, 4'hF, 32'h10}) begin
      n_bad++;
      $display("FAIL read_request: got cyc/stb/we=%b sel=%h addr=%h expected 110 f 00000010",
               {bus.wb_cyc, bus.wb_stb, bus.wb_we}, bus.wb_select, bus.wb_addr);
    end
    tick; tick;                                               // cycle 3
    n_cmp++;
    if ({bus.ready, bus.wb_stb} !== 2'b01) begin
      n_bad++;
      $display("FAIL read_wait: got ready/stb=%b expected 01", {bus.ready, bus.wb_stb});
    end
    bus.wb_ack = 1'b1; bus.wb_rdata = 32'hDEAD_BEEF;
    tick;                                                     // cycle 4
    bus.wb_ack = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata, bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_select} !==
        {2'b10, 32'hDEAD_BEEF, 3'b000, 4'h0}) begin
      n_bad++;
      $display("FAIL read_done: got ready=%b error=%b rdata=%h cyc/stb/we=%b sel=%h expected 1 0 deadbeef 000 0",
               bus.ready, bus.error, bus.rdata, {bus.wb_cyc, bus.wb_stb, bus.wb_we}, bus.wb_select);
    end
    bus.valid = 1'b0;
    tick;                                                     // cycle 5
    n_cmp++;
    if ({bus.ready, bus.rdata, bus.wb_stb} !== {1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL read_after: got ready=%b rdata=%h stb=%b expected 0 0 0",
               bus.ready, bus.rdata, bus.wb_stb);
    end
  endtask

  task automatic test_write;
    bus.valid = 1'b1; bus.address = 32'h20; bus.wdata = 32'h1234_5678; bus.wstrb = 4'h3;
    tick;                                                     // cycle 1
    n_cmp++;
    if ({bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_select, bus.wb_addr, bus.wb_wdata} !==
        {3'b111, 4'h3, 32'h20, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL write_request: got cyc/stb/we=%b sel=%h addr=%h data=%h expected 111 3 00000020 12345678",
               {bus.wb_cyc, bus.wb_stb, bus.wb_we}, bus.wb_select, bus.wb_addr, bus.wb_wdata);
    end
    bus.wb_ack = 1'b1; bus.wb_rdata = 32'hA5A5_A5A5;
    tick;                                                     // cycle 2
    bus.wb_ack = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata, bus.wb_stb, bus.wb_we, bus.wb_select} !==
        {2'b10, 32'h0, 2'b00, 4'h0}) begin
      n_bad++;
      $display("FAIL write_done: got ready=%b error=%b rdata=%h stb=%b we=%b sel=%h expected 1 0 0 0 0 0",
               bus.ready, bus.error, bus.rdata, bus.wb_stb, bus.wb_we, bus.wb_select);
    end
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    tick;
  endtask

  task automatic test_slave_error;
    bus.valid = 1'b1; bus.address = 32'h30; bus.wdata = '0; bus.wstrb = 4'h0;
    tick; tick;                                               // cycle 2
    bus.wb_ack = 1'b1; bus.wb_error = 1'b1; bus.wb_rdata = 32'hCAFE_F00D;
    tick;                                                     // cycle 3
    bus.wb_ack = 1'b0; bus.wb_error = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata, bus.wb_cyc} !== {2'b11, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL slave_error: got ready=%b error=%b rdata=%h cyc=%b expected 1 1 0 0",
               bus.ready, bus.error, bus.rdata, bus.wb_cyc);
    end
    bus.valid = 1'b0;
    tick;
    n_cmp++;
    if ({bus.ready, bus.error} !== 2'b00) begin
      n_bad++;
      $display("FAIL slave_error_clear: got ready/error=%b expected 00", {bus.ready, bus.error});
    end
  endtask

  task automatic test_timeout;
    int stb_cycles;
    stb_cycles = 0;
    bus.valid = 1'b1; bus.address = 32'h60; bus.wstrb = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (bus.wb_stb === 1'b1 && bus.ready === 1'b0) stb_cycles++;
    end
    n_cmp++;
    if (stb_cycles !== 5) begin
      n_bad++;
      $display("FAIL timeout_stb_span: got %0d cycles of stb without ready, expected 5", stb_cycles);
    end
    tick;                                                     // cycle 6
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata, bus.wb_cyc, bus.wb_stb} !== {2'b11, 32'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL timeout_done: got ready=%b error=%b rdata=%h cyc=%b stb=%b expected 1 1 0 0 0",
               bus.ready, bus.error, bus.rdata, bus.wb_cyc, bus.wb_stb);
    end
    bus.valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    bus.valid = 1'b1; bus.address = 32'h40; bus.wstrb = 4'h0;
    tick;                                                     // cycle 1
    bus.wb_ack = 1'b1; bus.wb_rdata = 32'h1111_1111;
    tick;                                                     // cycle 2: first ready
    bus.wb_ack = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.rdata} !== {1'b1, 32'h1111_1111}) begin
      n_bad++;
      $display("FAIL b2b_first: got ready=%b rdata=%h expected 1 11111111", bus.ready, bus.rdata);
    end
    bus.address = 32'h44;                                     // valid stays high
    tick;                                                     // cycle 3: IDLE
    n_cmp++;
    if ({bus.wb_stb, bus.ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_gap: got stb/ready=%b expected 00", {bus.wb_stb, bus.ready});
    end
    tick;                                                     // cycle 4
    n_cmp++;
    if ({bus.wb_stb, bus.wb_addr} !== {1'b1, 32'h44}) begin
      n_bad++;
      $display("FAIL b2b_second_stb: got stb=%b addr=%h expected 1 00000044", bus.wb_stb, bus.wb_addr);
    end
    bus.wb_ack = 1'b1; bus.wb_rdata = 32'h2222_2222;
    tick;                                                     // cycle 5
    bus.wb_ack = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata} !== {2'b10, 32'h2222_2222}) begin
      n_bad++;
      $display("FAIL b2b_second: got ready=%b error=%b rdata=%h expected 1 0 22222222",
               bus.ready, bus.error, bus.rdata);
    end
    bus.valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_bus;
    int ready_seen;
    ready_seen = 0;
    bus.valid = 1'b1; bus.address = 32'h50; bus.wstrb = 4'h0;
    tick;                                                     // cycle 1, in BUS
    n_cmp++;
    if (bus.wb_stb !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_pre: got stb=%b expected 1", bus.wb_stb);
    end
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wb_cyc, bus.wb_stb, bus.ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_drop: got cyc/stb/ready=%b expected 000",
               {bus.wb_cyc, bus.wb_stb, bus.ready});
    end
    bus.valid = 1'b0;
    bus.wb_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (bus.ready !== 1'b0) ready_seen++;
    end
    bus.wb_ack = 1'b0;
    arst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      if (bus.ready !== 1'b0 || bus.wb_stb !== 1'b0) ready_seen++;
    end
    n_cmp++;
    if (ready_seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_no_ready: got %0d cycles with ready/stb active, expected 0", ready_seen);
    end
    bus.valid = 1'b1; bus.address = 32'h54;
    tick;                                                     // cycle 1
    n_cmp++;
    if ({bus.wb_stb, bus.wb_addr} !== {1'b1, 32'h54}) begin
      n_bad++;
      $display("FAIL post_reset_req: got stb=%b addr=%h expected 1 00000054", bus.wb_stb, bus.wb_addr);
    end
    bus.wb_ack = 1'b1; bus.wb_rdata = 32'h0BAD_CAFE;
    tick;                                                     // cycle 2
    bus.wb_ack = 1'b0; bus.wb_rdata = '0;
    n_cmp++;
    if ({bus.ready, bus.error, bus.rdata} !== {2'b10, 32'h0BAD_CAFE}) begin
      n_bad++;
      $display("FAIL post_reset_done: got ready=%b error=%b rdata=%h expected 1 0 0badcafe",
               bus.ready, bus.error, bus.rdata);
    end
    bus.valid = 1'b0;
    tick;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_stray_response();
    test_read();
    test_write();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
